cordic_vectoring: RTL and testbench
===================================

// Module: cordic_vectoring
// PURPOSE
//  Iterative vectoring-mode CORDIC: the inverse of cordic_algorithm (rotation mode, theta -> sine/cosine).
//  Takes a signed (x,y) vector and returns angle = atan2(y,x) and gain-compensated magnitude.
//  Angle uses the same binary-angle format as theta: 0x4000 = 90 deg, 0x1555 = 30 deg, 0x8000 = +/-180 deg.
//  Sits after cordic_algorithm in loop-back/phase-detect paths; one vector processed at a time.
// PARAMETERS
//  DATA_W      16  width of x_in, y_in, angle, magnitude
//  ITERATIONS  14  micro-rotations per vector (1..15; iteration counter is 4 bits)
//  GUARD       2   extra MSBs on internal x/y datapath (prevents overflow from the 1.647 gain and sqrt2 growth)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  x_in       in   DATA_W  signed x component; sampled on accept
//  y_in       in   DATA_W  signed y component; sampled on accept
//  i_valid    in   1       request; accepted only when busy==0
//  busy       out  1       high from the accept edge until o_valid is asserted
//  o_valid    out  1       one-cycle pulse: angle/magnitude are valid
//  angle      out  DATA_W  signed binary angle, atan2(y_in,x_in); held until the next result
//  magnitude  out  DATA_W  unsigned sqrt(x^2+y^2); held until the next result
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, o_valid=0, angle=0, magnitude=0, i=0, x/y/z regs=0. Reset mid-operation aborts
//   the vector (no o_valid) and takes priority over everything else.
//  FSM (2-bit): IDLE -> ITER -> COMP -> IDLE.
//   IDLE: on an edge with i_valid=1, capture the inputs sign-extended to DATA_W+GUARD and apply the quadrant
//    pre-rotation: x_in<0 -> x=-x_in, y=-y_in, z=0x8000; otherwise x=x_in, y=y_in, z=0. Set i=0, busy=1,
//    zero_flag=(x_in==0 && y_in==0). Go to ITER. Negating -2^(DATA_W-1) is exact because of GUARD.
//   ITER: one micro-rotation per edge, arithmetic shifts:
//    y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i];  y<0: x-=y>>>i, y+=x>>>i, z-=ATAN[i]  (use old x/y on the right-hand side).
//    z wraps modulo 2^DATA_W. At i==ITERATIONS-1 go to COMP; otherwise i++.
//   COMP: angle<=z; magnitude<=sat((x*K_INV + 2^14)>>>15) with K_INV=0x4DBA (Q1.15, 1/1.6468);
//    saturate to 2^DATA_W-1. If zero_flag=1, force angle=0 and magnitude=0. Assert o_valid, clear busy, go to IDLE.
//  Latency: accept edge E0, iterations at E1..E_ITERATIONS, outputs registered at E_(ITERATIONS+1);
//   o_valid is high in the cycle that follows (ITERATIONS+2 edges per vector, default 16).
//  i_valid while busy=1: ignored (no queueing). i_valid in the o_valid cycle: accepted (state is already IDLE),
//   giving back-to-back throughput of one vector per ITERATIONS+2 cycles.
//  Inputs change while busy: no effect. Outputs change only on the COMP edge or on reset.
//  Accuracy: |angle error| <= 4 LSB; |magnitude error| <= 4 LSB + 0.1% for |vector| >= 64.
// STRUCTURE
//  cordic_pkg (shared with cordic_algorithm): ATAN table in binary-angle LSBs (0x2000, 0x12E4, 0x09FB,
//   0x0511, 0x028B, 0x0146, 0x00A3, 0x0051, 0x0029, 0x0014, 0x000A, 0x0005, 0x0003, 0x0001, 0x0001),
//   K_INV, ANGLE_PI=0x8000, and the 2-bit state encodings IDLE/ITER/COMP.
//  Sub-module: cordic_atan_lut (combinational, i -> ATAN[i]), also reusable by cordic_algorithm.
//  The state, i, x_reg, y_reg and z_reg names stay visible to hierarchical bench probes.
// TESTING
//  1 (16384,0) -> angle 0x0000 +/-4, magnitude 16384 +/-20, o_valid after exactly 16 edges, one-cycle pulse.
//  2 (0,16384) -> 0x4000; (14189,8192) -> 0x1555 (30 deg), magnitude 16384 +/-20.
//  3 Left half-plane: (-16384,0) -> 0x8000; (-16384,-16384) -> 0xA000 (-135 deg), magnitude 23170 +/-25;
//    (-32768,0) -> 0x8000, magnitude 32768 saturates to 65535? No: 32768 fits; expect 32768 +/-40.
//  4 (0,0) -> angle 0, magnitude 0. (32767,32767) -> 0x2000, magnitude 46339 +/-50, no overflow.
//  5 Handshake: i_valid held high continuously -> new accept on each o_valid cycle, 16-cycle period;
//    a second i_valid pulse while busy is dropped; reset asserted at iteration 5 -> no o_valid, all outputs 0.
//  6 Loop-back: theta sweep 0x0000..0xFFFF step 0x0111 into cordic_algorithm, its (cosine,sine) into this
//    block -> angle == theta +/-8 LSB with wrap, self-checking with an error counter.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: arctangent table, gain compensation and FSM encodings.
package cordic_pkg;

    // atan(2^-i) in binary-angle LSBs (0x4000 = 90 deg); the last entry pads the
    // table to the full 4-bit index range so any counter value has a defined lookup.
    localparam logic [15:0] ATAN_TABLE [16] = '{
        16'h2000, 16'h12E4, 16'h09FB, 16'h0511,
        16'h028B, 16'h0146, 16'h00A3, 16'h0051,
        16'h0029, 16'h0014, 16'h000A, 16'h0005,
        16'h0003, 16'h0001, 16'h0001, 16'h0000
    };

    // 1/1.6468 in Q1.15, removes the CORDIC gain from the final x value.
    localparam logic [15:0] K_INV    = 16'h4DBA;

    // Binary-angle representation of +/-180 degrees.
    localparam logic [15:0] ANGLE_PI = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        COMP = 2'd2
    } state_t;

endpackage

// File: rtl/cordic_vectoring_if.sv
// Request/result bundle between a vector source and the vectoring CORDIC.
interface cordic_vectoring_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] x_in;
    logic [DATA_W-1:0] y_in;
    logic              i_valid;
    logic              busy;
    logic              o_valid;
    logic [DATA_W-1:0] angle;
    logic [DATA_W-1:0] magnitude;

    modport master (
        output x_in, y_in, i_valid,
        input  busy, o_valid, angle, magnitude
    );

    modport slave (
        input  x_in, y_in, i_valid,
        output busy, o_valid, angle, magnitude
    );
endinterface

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent lookup: iteration index -> atan(2^-i) in binary angle.
module cordic_atan_lut
    import cordic_pkg::*;
(
    input  logic [3:0]  idx_i,
    output logic [15:0] atan_o
);

    // Pure table read; the table covers all 16 index values.
    always_comb begin
        atan_o = ATAN_TABLE[idx_i];
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x,y) -> atan2(y,x) and gain-compensated magnitude.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ITERATIONS = 14,
    parameter int GUARD      = 2
) (
    input  logic               clk,
    input  logic               reset,
    cordic_vectoring_if.slave  bus
);

    localparam int         W         = DATA_W + GUARD;
    localparam int         PW        = W + 17;
    localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);

    state_t                   state, state_d;
    logic [3:0]               i, i_d;
    logic signed [W-1:0]      x_reg, x_d;
    logic signed [W-1:0]      y_reg, y_d;
    logic [DATA_W-1:0]        z_reg, z_d;
    logic                     zero_flag_q, zero_flag_d;
    logic                     o_valid_q, o_valid_d;
    logic [DATA_W-1:0]        angle_q, angle_d;
    logic [DATA_W-1:0]        magnitude_q, magnitude_d;

    logic [15:0]              atan_raw;
    logic [DATA_W-1:0]        atan_val;
    logic signed [W-1:0]      x_ext, y_ext;
    logic signed [W-1:0]      x_sh, y_sh;
    logic signed [PW-1:0]     mag_prod, mag_scaled;
    logic [DATA_W-1:0]        mag_sat;

    cordic_atan_lut u_atan_lut (
        .idx_i  (i),
        .atan_o (atan_raw)
    );

    assign atan_val = DATA_W'(atan_raw);

    // Inputs widened by GUARD bits so negating the most negative input and the
    // ~2.33x worst-case growth of x both fit without overflow.
    assign x_ext = {{GUARD{bus.x_in[DATA_W-1]}}, bus.x_in};
    assign y_ext = {{GUARD{bus.y_in[DATA_W-1]}}, bus.y_in};
    assign x_sh  = x_reg >>> i;
    assign y_sh  = y_reg >>> i;

    // Gain compensation with round-half-up, then clamp into the unsigned output range.
    always_comb begin
        mag_prod   = x_reg * $signed({1'b0, K_INV});
        mag_scaled = (mag_prod + PW'(32'sd16384)) >>> 15;
        if (mag_scaled[PW-1])
            mag_sat = '0;
        else if (|mag_scaled[PW-2:DATA_W])
            mag_sat = '1;
        else
            mag_sat = mag_scaled[DATA_W-1:0];
    end

    // Register bank; reset clears every state and output register and overrides the FSM.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values computed by the combinational block.
        if (reset) begin
            state       <= IDLE;
            i           <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            z_reg       <= '0;
            zero_flag_q <= 1'b0;
            o_valid_q   <= 1'b0;
            angle_q     <= '0;
            magnitude_q <= '0;
        end else begin
            state       <= state_d;
            i           <= i_d;
            x_reg       <= x_d;
            y_reg       <= y_d;
            z_reg       <= z_d;
            zero_flag_q <= zero_flag_d;
            o_valid_q   <= o_valid_d;
            angle_q     <= angle_d;
            magnitude_q <= magnitude_d;
        end
    end

    // Next-state logic: accept/pre-rotate, micro-rotate, then compensate and publish.
    always_comb begin
        // NOTE: every target gets a hold/default value first, so no path through
        // the case statement can leave a signal unassigned and infer a latch.
        state_d     = state;
        i_d         = i;
        x_d         = x_reg;
        y_d         = y_reg;
        z_d         = z_reg;
        zero_flag_d = zero_flag_q;
        o_valid_d   = 1'b0;
        angle_d     = angle_q;
        magnitude_d = magnitude_q;

        case (state)
            IDLE: begin
                if (bus.i_valid) begin
                    // Fold the left half-plane onto the right by a 180 degree turn.
                    if (bus.x_in[DATA_W-1]) begin
                        x_d = -x_ext;
                        y_d = -y_ext;
                        z_d = DATA_W'(ANGLE_PI);
                    end else begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end
                    i_d         = '0;
                    zero_flag_d = (bus.x_in == '0) && (bus.y_in == '0);
                    state_d     = ITER;
                end
            end

            ITER: begin
                // Rotate towards the x axis; the accumulated angle tracks the rotation.
                if (!y_reg[W-1]) begin
                    x_d = x_reg + y_sh;
                    y_d = y_reg - x_sh;
                    z_d = z_reg + atan_val;
                end else begin
                    x_d = x_reg - y_sh;
                    y_d = y_reg + x_sh;
                    z_d = z_reg - atan_val;
                end
                if (i == LAST_ITER)
                    state_d = COMP;
                else
                    i_d = i + 4'd1;
            end

            COMP: begin
                angle_d     = zero_flag_q ? '0 : z_reg;
                magnitude_d = zero_flag_q ? '0 : mag_sat;
                o_valid_d   = 1'b1;
                state_d     = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state != IDLE);
    assign bus.o_valid   = o_valid_q;
    assign bus.angle     = angle_q;
    assign bus.magnitude = magnitude_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed self-checking bench for the vectoring CORDIC.
module tb_cordic_vectoring;
    import cordic_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cordic_vectoring_if #(.DATA_W(16)) vif ();

    cordic_vectoring #(
        .DATA_W     (16),
        .ITERATIONS (14),
        .GUARD      (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] ang;
        int          atol;
        int          mag;
        int          mtol;
    } vec_t;

    // Wrapped distance between two binary angles.
    function automatic int ang_err(input logic [15:0] a, input logic [15:0] e);
        logic signed [15:0] d;
        d = a - e;
        return (d < 0) ? -int'(d) : int'(d);
    endfunction

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Launch one vector and wait (bounded) for its o_valid; edges counts E0..result edge.
    task automatic run_vec(input int x, input int y, output logic [15:0] ang,
                           output logic [15:0] mag, output int edges, output bit ok);
        @(negedge clk);
        vif.x_in    = 16'(x);
        vif.y_in    = 16'(y);
        vif.i_valid = 1'b1;
        @(posedge clk);
        edges = 1;
        ok    = 1'b0;
        @(negedge clk);
        vif.i_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (vif.o_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        ang = vif.angle;
        mag = vif.magnitude;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        vif.i_valid = 1'b0;
        vif.x_in    = '0;
        vif.y_in    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (vif.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", vif.busy); end
        tests++;
        if (vif.o_valid !== 1'b0) begin fails++; $display("FAIL reset_o_valid got=%b exp=0", vif.o_valid); end
        tests++;
        if (vif.angle !== 16'h0000) begin fails++; $display("FAIL reset_angle got=%h exp=0000", vif.angle); end
        tests++;
        if (vif.magnitude !== 16'h0000) begin fails++; $display("FAIL reset_magnitude got=%0d exp=0", vif.magnitude); end
        tests++;
        if (dut.state !== IDLE) begin fails++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
    endtask

    task automatic test_directed();
        vec_t tbl [10] = '{
            '{ 16384,      0, 16'h0000, 4, 16384, 20},
            '{     0,  16384, 16'h4000, 4, 16384, 20},
            '{ 14189,   8192, 16'h1555, 4, 16384, 20},
            '{-16384,      0, 16'h8000, 4, 16384, 20},
            '{-16384, -16384, 16'hA000, 4, 23170, 25},
            '{-32768,      0, 16'h8000, 4, 32768, 40},
            '{     0,      0, 16'h0000, 0,     0,  0},
            '{ 32767,  32767, 16'h2000, 4, 46339, 50},
            '{     0, -16384, 16'hC000, 4, 16384, 20},
            '{-32768, -32768, 16'hA000, 4, 46341, 50}
        };
        logic [15:0] ang, mag;
        int          edges;
        bit          ok;
        for (int n = 0; n < 10; n++) begin
            run_vec(tbl[n].x, tbl[n].y, ang, mag, edges, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL vec%0d_timeout got=no o_valid exp=o_valid within 40 edges", n);
            end else begin
                tests++;
                if (ang_err(ang, tbl[n].ang) > tbl[n].atol) begin
                    fails++;
                    $display("FAIL vec%0d_angle (%0d,%0d) got=%h exp=%h +/-%0d",
                             n, tbl[n].x, tbl[n].y, ang, tbl[n].ang, tbl[n].atol);
                end
                tests++;
                if (abs_i(int'(mag) - tbl[n].mag) > tbl[n].mtol) begin
                    fails++;
                    $display("FAIL vec%0d_magnitude (%0d,%0d) got=%0d exp=%0d +/-%0d",
                             n, tbl[n].x, tbl[n].y, mag, tbl[n].mag, tbl[n].mtol);
                end
            end
        end
    endtask

    task automatic test_latency();
        int  edges;
        bit  seen;
        @(negedge clk);
        vif.x_in    = 16'sd16384;
        vif.y_in    = 16'sd0;
        vif.i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vif.i_valid = 1'b0;
        tests++;
        if (vif.busy !== 1'b1) begin fails++; $display("FAIL lat_busy_after_accept got=%b exp=1", vif.busy); end
        edges = 1;
        seen  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (vif.o_valid) begin seen = 1'b1; break; end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        tests++;
        if (!seen || edges != 16) begin
            fails++;
            $display("FAIL lat_edges got=%0d seen=%b exp=16", edges, seen);
        end
        tests++;
        if (vif.busy !== 1'b0) begin fails++; $display("FAIL lat_busy_in_valid_cycle got=%b exp=0", vif.busy); end
        @(negedge clk);
        tests++;
        if (vif.o_valid !== 1'b0) begin fails++; $display("FAIL lat_pulse_width got=%b exp=0", vif.o_valid); end
    endtask

    task automatic test_back_to_back();
        int last_edge, cyc, pulses;
        @(negedge clk);
        vif.x_in    = 16'sd8192;
        vif.y_in    = 16'sd8192;
        vif.i_valid = 1'b1;
        cyc       = 0;
        pulses    = 0;
        last_edge = 0;
        while (pulses < 3 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (vif.o_valid) begin
                pulses++;
                tests++;
                if (ang_err(vif.angle, 16'h2000) > 4) begin
                    fails++;
                    $display("FAIL b2b_angle%0d got=%h exp=2000 +/-4", pulses, vif.angle);
                end
                if (pulses > 1) begin
                    tests++;
                    if (cyc - last_edge != 16) begin
                        fails++;
                        $display("FAIL b2b_period%0d got=%0d exp=16", pulses, cyc - last_edge);
                    end
                end
                last_edge = cyc;
            end
        end
        tests++;
        if (pulses != 3) begin fails++; $display("FAIL b2b_pulses got=%0d exp=3", pulses); end
        vif.i_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (vif.busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_after_drop got=%b exp=0", vif.busy); end
    endtask

    task automatic test_busy_drop();
        int  extra;
        bit  seen;
        @(negedge clk);
        vif.x_in    = 16'sd16384;
        vif.y_in    = 16'sd0;
        vif.i_valid = 1'b1;
        @(negedge clk);
        vif.i_valid = 1'b0;
        repeat (3) @(negedge clk);
        // Second request while busy, with different inputs that must not leak in.
        vif.x_in    = 16'sd0;
        vif.y_in    = 16'sd16384;
        vif.i_valid = 1'b1;
        @(negedge clk);
        vif.i_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (vif.o_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL drop_timeout got=no o_valid exp=o_valid");
        end else begin
            tests++;
            if (ang_err(vif.angle, 16'h0000) > 4) begin
                fails++;
                $display("FAIL drop_angle got=%h exp=0000 +/-4", vif.angle);
            end
        end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (vif.o_valid) extra++;
        end
        tests++;
        if (extra != 0) begin fails++; $display("FAIL drop_extra_results got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        int extra;
        @(negedge clk);
        vif.x_in    = 16'sd16384;
        vif.y_in    = 16'sd16384;
        vif.i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vif.i_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        tests++;
        if (dut.i !== 4'd5) begin fails++; $display("FAIL mid_iter_index got=%0d exp=5", dut.i); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (vif.busy !== 1'b0) begin fails++; $display("FAIL mid_busy got=%b exp=0", vif.busy); end
        tests++;
        if (vif.magnitude !== 16'h0000) begin fails++; $display("FAIL mid_magnitude got=%0d exp=0", vif.magnitude); end
        tests++;
        if (vif.angle !== 16'h0000) begin fails++; $display("FAIL mid_angle got=%h exp=0000", vif.angle); end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (vif.o_valid) extra++;
        end
        tests++;
        if (extra != 0) begin fails++; $display("FAIL mid_o_valid got=%0d pulses exp=0", extra); end
    endtask

    task automatic test_loopback();
        logic [15:0] ang, mag;
        int          edges, x, y, err_cnt;
        bit          ok;
        real         th;
        err_cnt = 0;
        for (int t = 0; t <= 16'hFFFF; t += 16'h0111) begin
            th = real'(t) * 6.283185307179586 / 65536.0;
            x  = $rtoi($floor(16384.0 * $cos(th) + 0.5));
            y  = $rtoi($floor(16384.0 * $sin(th) + 0.5));
            run_vec(x, y, ang, mag, edges, ok);
            tests++;
            if (!ok || ang_err(ang, 16'(t)) > 8) begin
                fails++;
                err_cnt++;
                $display("FAIL loop_theta_%h got=%h ok=%b exp=%h +/-8", 16'(t), ang, ok, 16'(t));
            end
        end
        if (err_cnt != 0) $display("[TB] loop-back errors: %0d", err_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_back_to_back();
        test_busy_drop();
        test_reset_mid();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
